// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants and state encoding for the instruction-fetch responder.
package inst_fetch_responder_pkg;

    // Byte geometry of one instruction word
    localparam int BYTE_LEN       = 8;
    localparam int BYTES_PER_INST = 4;

    // Width of the staging buffer that holds bytes 0..2 while byte 3 is in flight
    localparam int BUF_LEN = BYTE_LEN * (BYTES_PER_INST - 1);

    // Edge-counter milestones, counted in edges after the accepting edge E0
    localparam logic [2:0] LAST_ISSUE_EDGE    = 3'd3; // last address (A+3) driven
    localparam logic [2:0] RD_OFF_EDGE        = 3'd4; // read strobe released
    localparam logic [2:0] FIRST_CAPTURE_EDGE = 3'd2; // byte 0 arrives from the RAM
    localparam logic [2:0] DONE_EDGE          = 3'd5; // byte 3 arrives, word complete

    // Responder states
    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_READ = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: turns one CPU fetch request into four byte
// reads on a registered byte-wide RAM and returns the little-endian 32-bit
// word with a one-cycle valid pulse. busy_o stalls the CPU while a fetch is
// in flight; flush_i abandons it without a pulse.
//
// Handshake: a request is taken only on an edge where the responder is
// idle, req_ce_i=1 and flush_i=0; the address is latched on that edge and
// later changes are ignored. The CPU keeps req_ce_i high until it sees
// busy_o drop and the request accepted. inst_valid_o is high for exactly
// one cycle per completed fetch; inst_o holds that word until the next one.
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                req_ce_i,
    input  logic [ADDR_LEN-1:0] req_addr_i,
    input  logic                flush_i,
    output logic                busy_o,
    output logic [INST_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    output logic [ADDR_LEN-1:0] mem_a_o,
    output logic                mem_rd_o,
    input  logic [7:0]          mem_din_i
);

    fetch_state_t        state;
    logic [2:0]          edge_cnt;   // edges since acceptance; next edge index while reading
    logic [ADDR_LEN-1:0] base_addr;  // latched fetch address A
    logic [BUF_LEN-1:0]  byte_buf;   // bytes 2..0, byte 0 ends up in the low lane

    // Fetch FSM with counter, address issue, byte capture and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= FETCH_IDLE;
            edge_cnt     <= 3'd0;
            base_addr    <= '0;
            byte_buf     <= '0;
            busy_o       <= 1'b0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
            mem_a_o      <= '0;
            mem_rd_o     <= 1'b0;
        end else begin
            // The valid pulse lasts one cycle unless re-asserted below
            inst_valid_o <= 1'b0;

            case (state)
                FETCH_IDLE: begin
                    // Flush wins over a simultaneous request
                    if (req_ce_i && !flush_i) begin
                        base_addr <= req_addr_i;
                        mem_a_o   <= req_addr_i;
                        mem_rd_o  <= 1'b1;
                        busy_o    <= 1'b1;
                        edge_cnt  <= 3'd1;
                        byte_buf  <= '0;
                        state     <= FETCH_READ;
                    end
                end

                FETCH_READ: begin
                    if (flush_i) begin
                        // Drop everything gathered so far; inst_o keeps the last word
                        state    <= FETCH_IDLE;
                        busy_o   <= 1'b0;
                        mem_rd_o <= 1'b0;
                        edge_cnt <= 3'd0;
                        byte_buf <= '0;
                    end else begin
                        edge_cnt <= edge_cnt + 3'd1;

                        // Walk the address A+1..A+3, wrapping modulo 2^ADDR_LEN
                        if (edge_cnt <= LAST_ISSUE_EDGE) begin
                            mem_a_o <= base_addr + ADDR_LEN'(edge_cnt);
                        end

                        if (edge_cnt == RD_OFF_EDGE) begin
                            mem_rd_o <= 1'b0;
                        end

                        // Bytes 0..2 shift in from the top so byte 0 lands lowest
                        if (edge_cnt >= FIRST_CAPTURE_EDGE && edge_cnt < DONE_EDGE) begin
                            byte_buf <= {mem_din_i, byte_buf[BUF_LEN-1:BYTE_LEN]};
                        end

                        // Byte 3 comes straight off the RAM bus into the final word
                        if (edge_cnt == DONE_EDGE) begin
                            inst_o       <= {mem_din_i, byte_buf};
                            inst_valid_o <= 1'b1;
                            busy_o       <= 1'b0;
                            edge_cnt     <= 3'd0;
                            state        <= FETCH_IDLE;
                        end
                    end
                end

                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with a registered byte RAM model.
module tb_inst_fetch_responder;

    // ---------------- clock / reset ----------------
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_ce_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic [7:0]  mem_din_i = 8'h00;

    always #5 clk_in = ~clk_in;

    inst_fetch_responder #(.ADDR_LEN(32), .INST_LEN(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req_ce_i     (req_ce_i),
        .req_addr_i   (req_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .mem_a_o      (mem_a_o),
        .mem_rd_o     (mem_rd_o),
        .mem_din_i    (mem_din_i)
    );

    // ---------------- RAM model: one-cycle registered byte read ----------------
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_read(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    always @(posedge clk_in) begin
        if (mem_rd_o) mem_din_i <= ram_read(mem_a_o);
    end

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_inst;
    } fetch_vec_t;

    fetch_vec_t vecs [6];

    task automatic preload(input logic [31:0] a, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        ram[a]         = b0;
        ram[a + 32'd1] = b1;
        ram[a + 32'd2] = b2;
        ram[a + 32'd3] = b3;
    endtask

    // Full single fetch with per-edge checks; request dropped right after E0
    task automatic do_fetch(input fetch_vec_t v);
        preload(v.addr, v.b0, v.b1, v.b2, v.b3);
        @(negedge clk_in);
        req_ce_i   = 1'b1;
        req_addr_i = v.addr;
        @(negedge clk_in);                  // E0 has passed
        req_ce_i   = 1'b0;
        req_addr_i = $urandom();            // must be ignored from here on
        check("e0_busy", 32'(busy_o), 32'd1);
        check("e0_rd", 32'(mem_rd_o), 32'd1);
        check("e0_addr", mem_a_o, v.addr);
        check("e0_valid", 32'(inst_valid_o), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_in);
            check("issue_addr", mem_a_o, v.addr + 32'(k));
            check("issue_rd", 32'(mem_rd_o), 32'd1);
            check("issue_valid", 32'(inst_valid_o), 32'd0);
        end
        @(negedge clk_in);                  // after E4
        check("e4_rd", 32'(mem_rd_o), 32'd0);
        check("e4_addr", mem_a_o, v.addr + 32'd3);
        check("e4_busy", 32'(busy_o), 32'd1);
        check("e4_valid", 32'(inst_valid_o), 32'd0);
        @(negedge clk_in);                  // after E5
        check("e5_valid", 32'(inst_valid_o), 32'd1);
        check("e5_inst", inst_o, v.exp_inst);
        check("e5_busy", 32'(busy_o), 32'd0);
        @(negedge clk_in);                  // after E6
        check("e6_valid", 32'(inst_valid_o), 32'd0);
        check("e6_inst", inst_o, v.exp_inst);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        fetch_vec_t v;

        vecs[0] = '{addr: 32'h0000_0100, b0: 8'h13, b1: 8'h05, b2: 8'hA0, b3: 8'h00, exp_inst: 32'h00A0_0513};
        vecs[1] = '{addr: 32'h0000_0000, b0: 8'h93, b1: 8'h00, b2: 8'h10, b3: 8'h00, exp_inst: 32'h0010_0093};
        vecs[2] = '{addr: 32'hFFFF_FFFE, b0: 8'hAA, b1: 8'hBB, b2: 8'hCC, b3: 8'hDD, exp_inst: 32'hDDCC_BBAA};
        vecs[3] = '{addr: 32'h0000_0203, b0: 8'h11, b1: 8'h22, b2: 8'h33, b3: 8'h44, exp_inst: 32'h4433_2211};
        vecs[4] = '{addr: 32'h7FFF_FFFC, b0: 8'hEF, b1: 8'hBE, b2: 8'hAD, b3: 8'hDE, exp_inst: 32'hDEAD_BEEF};
        vecs[5] = '{addr: 32'h0000_0400, b0: 8'h67, b1: 8'h80, b2: 8'h00, b3: 8'h00, exp_inst: 32'h0000_8067};

        // Reset state
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_addr", mem_a_o, 32'h0);
        check("rst_rd", 32'(mem_rd_o), 32'd0);

        // Table of single fetches
        for (int i = 0; i < 6; i++) do_fetch(vecs[i]);

        // Back-to-back: request held high, address switched after E0
        preload(32'h0, 8'h93, 8'h00, 8'h10, 8'h00);
        preload(32'h4, 8'h13, 8'h01, 8'h20, 8'h00);
        @(negedge clk_in);
        req_ce_i   = 1'b1;
        req_addr_i = 32'h0;
        @(negedge clk_in);                  // E0
        req_addr_i = 32'h4;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk_in);
            check("b2b_valid", 32'(inst_valid_o), 32'((cyc == 5) || (cyc == 11)));
            if (cyc == 5) begin
                check("b2b_inst0", inst_o, 32'h0010_0093);
                check("b2b_busy_gap", 32'(busy_o), 32'd0);
            end
            if (cyc == 6) begin
                check("b2b_accept_busy", 32'(busy_o), 32'd1);
                check("b2b_accept_addr", mem_a_o, 32'h4);
                req_ce_i = 1'b0;
            end
            if (cyc == 11) check("b2b_inst1", inst_o, 32'h0020_0113);
        end

        // Flush at E3: no pulse, previous word retained, next request accepted
        preload(32'h500, 8'h01, 8'h02, 8'h03, 8'h04);
        @(negedge clk_in);
        req_ce_i   = 1'b1;
        req_addr_i = 32'h500;
        @(negedge clk_in);                  // E0
        req_ce_i = 1'b0;
        @(negedge clk_in);                  // E1
        @(negedge clk_in);                  // E2
        flush_i = 1'b1;
        @(negedge clk_in);                  // E3 with flush
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_rd", 32'(mem_rd_o), 32'd0);
        check("flush_valid", 32'(inst_valid_o), 32'd0);
        check("flush_inst_kept", inst_o, 32'h0020_0113);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk_in);
            check("flush_no_pulse", 32'(inst_valid_o), 32'd0);
        end
        v = '{addr: 32'h0000_0500, b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, exp_inst: 32'h0403_0201};
        do_fetch(v);

        // Flush and request together while idle: not accepted
        @(negedge clk_in);
        req_ce_i   = 1'b1;
        req_addr_i = 32'h600;
        flush_i    = 1'b1;
        @(negedge clk_in);
        check("idle_flush_busy", 32'(busy_o), 32'd0);
        check("idle_flush_rd", 32'(mem_rd_o), 32'd0);
        check("idle_flush_addr", mem_a_o, 32'h503);
        req_ce_i = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk_in);
        check("idle_flush_rd2", 32'(mem_rd_o), 32'd0);

        // Reset asserted at E2 of a fetch, then a fresh fetch
        preload(32'h700, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        @(negedge clk_in);
        req_ce_i   = 1'b1;
        req_addr_i = 32'h700;
        @(negedge clk_in);                  // E0
        req_ce_i = 1'b0;
        @(negedge clk_in);                  // E1
        rst_in = 1'b1;
        @(negedge clk_in);                  // E2 under reset
        rst_in = 1'b0;
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_inst", inst_o, 32'h0);
        check("mrst_valid", 32'(inst_valid_o), 32'd0);
        check("mrst_addr", mem_a_o, 32'h0);
        check("mrst_rd", 32'(mem_rd_o), 32'd0);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk_in);
            check("mrst_no_pulse", 32'(inst_valid_o), 32'd0);
        end
        do_fetch(vecs[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Responder side of the CPU instruction-fetch interface (chip-enable plus address in, instruction out).
- Replaces the ideal combinational ROM with a byte-wide synchronous RAM port.
- On each accepted fetch it reads four consecutive bytes and assembles them little-endian into one 32-bit instruction.
- It returns the instruction with a one-cycle valid pulse and holds busy high meanwhile, so the CPU stalls.

Parameters:
ADDR_LEN, 32, fetch and RAM address width (matches `AddrLen)
INST_LEN, 32, instruction width; fixed at 32 (4 bytes), other values unsupported

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, synchronous, active-high
req_ce_i  in  1  fetch request from CPU
req_addr_i  in  ADDR_LEN  byte address of instruction
flush_i  in  1  abort in-flight fetch (branch/jump redirect)
busy_o  out  1  responder occupied; request ignored while high
inst_o  out  INST_LEN  assembled instruction
inst_valid_o  out  1  one-cycle pulse: inst_o valid
mem_a_o  out  ADDR_LEN  byte address to RAM
mem_rd_o  out  1  RAM read strobe
mem_din_i  in  8  RAM read data, valid one cycle after address (registered RAM)

Behaviour:
- All outputs are registered. Reset: busy_o=0, inst_o=0, inst_valid_o=0, mem_a_o=0, mem_rd_o=0, state IDLE, byte buffer=0.
- Reset mid-fetch: abandon immediately, same values, no valid pulse.
- States: IDLE, READ, finishing back in IDLE. A 3-bit edge counter tracks progress.
- Accept at edge E0: in IDLE, req_ce_i=1, flush_i=0.
  - Latch A = req_addr_i.
  - mem_a_o<=A, mem_rd_o<=1, busy_o<=1, go to READ.
  - req_addr_i changes after E0 are ignored.
- Issue:
  - E1, E2, E3: mem_a_o<=A+1, A+2, A+3.
  - E4: mem_rd_o<=0, mem_a_o holds A+3.
- Capture: byte k (address A+k) is sampled from mem_din_i at edge E(k+2), k=0..3.
- Assembly:
  - Byte k goes to bits [8k+7:8k].
  - At E5 inst_o<={byte3,byte2,byte1,byte0}, inst_valid_o<=1, busy_o<=0, state IDLE.
  - Byte3 is taken directly from mem_din_i at E5.
- Pulse: inst_valid_o returns to 0 at E6.
- inst_o: holds its value until the next completed fetch. It does not change on flush or IDLE.
- Latency and throughput:
  - inst_valid_o rises 5 edges after the accepting edge.
  - A request held high through E5 is accepted at E6 (busy_o=0 during that cycle).
  - Peak rate is one instruction per 6 cycles.
- Address arithmetic: A+k is modulo 2^ADDR_LEN; 0xFFFFFFFE wraps to 0x00000000, 0x00000001.
- Alignment: no alignment check; any byte address is fetched as given.
- Flush, at any edge while busy_o=1 (E1..E5):
  - Next state IDLE, busy_o<=0, mem_rd_o<=0, no valid pulse.
  - Partially captured bytes are discarded; inst_o is unchanged.
- Flush in IDLE with req_ce_i=1: flush wins, request not accepted.
- Request while busy (without flush): ignored. The CPU must keep req_ce_i high until it observes busy_o=0 and then sees acceptance.
- Valid/new request overlap: the valid pulse (cycle after E5) may coincide with the cycle in which a new request is sampled. Both are legal.

Decomposition:
- Shared config.vh gains:
  - `ByteLen 8
  - `BytesPerInst 4
  - state encodings `FetchIdle / `FetchRead
- Reuses `AddrLen and `InstLen.
- No sub-module: counter, FSM and byte shift buffer fit in one module.
- The bench RAM model (1-cycle registered byte read) lives in the sim directory, not RTL.

Test Plan:
- Single fetch: RAM[0x100..0x103]=13,05,A0,00; req at 0x100 -> mem_a_o 0x100..0x103 on E0..E3, inst_o=0x00A00513 with valid exactly one cycle after E5, busy_o high E0..E5.
- Back-to-back: req_ce_i held high at 0x0 then 0x4 -> second accept at E6, valid pulses 6 cycles apart, correct words from each address.
- Wrap: req at 0xFFFFFFFE, RAM[FFFFFFFE]=AA, [FFFFFFFF]=BB, [0]=CC, [1]=DD -> mem_a_o sequence FFFFFFFE, FFFFFFFF, 0, 1; inst_o=0xDDCCBBAA.
- Flush at E3 -> no valid pulse, busy_o=0 next cycle, inst_o retains previous word; a request at the next edge is accepted normally.
- Flush and req in IDLE in the same cycle -> not accepted, mem_rd_o stays 0.
- rst_in asserted at E2 -> all outputs 0 next cycle; a request after reset release returns a fresh correct instruction.
